// File: rtl/dram_bank_cmd_fsm_if.sv
// Request / command bus for dram_bank_cmd_fsm.
//   master : front end side. It drives req_* and observes req_ready, cmd_* and done.
//   slave  : the sequencer side.
//   req_valid/req_ready : request handshake.
//   req_write, req_bank, req_row : request payload.
//   cmd_valid, cmd_op, cmd_bank, cmd_row : one-cycle DRAM command strobe.
//   done : one-cycle pulse when a request completes.
interface dram_bank_cmd_fsm_if #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [BANK_W-1:0] cmd_bank;
    logic [ROW_W-1:0]  cmd_row;
    logic              done;

    modport master (
        output req_valid, req_write, req_bank, req_row,
        input  req_ready, cmd_valid, cmd_op, cmd_bank, cmd_row, done
    );
    modport slave (
        input  req_valid, req_write, req_bank, req_row,
        output req_ready, cmd_valid, cmd_op, cmd_bank, cmd_row, done
    );
endinterface

// File: rtl/dram_bank_cmd_fsm.sv
// Multi-bank DRAM command sequencer. The block accepts one read or write request
// at a time and tracks the open row of every bank. It issues ACT, RD, WR, PRE,
// PREA and REF commands with fixed spacing, and it schedules periodic refresh
// on its own.
//   CLK, RST    : clock and synchronous active-high reset
//   init_done   : DRAM init complete. init_req stays high while in INIT.
//   ref_pending : a refresh is owed and has not been issued yet
//   bus         : request handshake, command strobe and done pulse (slave side)
module dram_bank_cmd_fsm #(
    parameter int NUM_BANKS   = 4,
    parameter int ROW_W       = 14,
    parameter int TRP         = 3,
    parameter int TRCD        = 3,
    parameter int TRD         = 4,
    parameter int TWR         = 5,
    parameter int TRFC        = 8,
    parameter int TREFI       = 100,
    parameter int CLOSED_PAGE = 0,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic init_done,
    output logic init_req,
    output logic ref_pending,
    dram_bank_cmd_fsm_if.slave bus
);
    localparam int T1    = (TRP > TRCD) ? TRP : TRCD;
    localparam int T2    = (TRD > TWR) ? TRD : TWR;
    localparam int T3    = (T1 > T2) ? T1 : T2;
    localparam int TMAX  = (T3 > TRFC) ? T3 : TRFC;
    localparam int CNT_W = $clog2(TMAX);
    localparam int REF_W = $clog2(TREFI);

    localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                           OP_PRE = 3'd4, OP_PREA = 3'd5, OP_REF = 3'd6;

    localparam logic [3:0] S_INIT = 4'd0,  S_IDLE = 4'd1,  S_PRE = 4'd2,  S_PRE_WAIT = 4'd3,
                           S_ACT = 4'd4,   S_ACT_WAIT = 4'd5, S_RW = 4'd6, S_RW_WAIT = 4'd7,
                           S_CPRE = 4'd8,  S_CPRE_WAIT = 4'd9, S_PREA = 4'd10,
                           S_PREA_WAIT = 4'd11, S_REF = 4'd12, S_REF_WAIT = 4'd13;

    logic [3:0]                       state;
    logic [CNT_W-1:0]                 wait_cnt;
    logic [REF_W-1:0]                 ref_cnt;
    logic                             lat_write;
    logic [BANK_W-1:0]                lat_bank;
    logic [ROW_W-1:0]                 lat_row;
    logic [NUM_BANKS-1:0]             valid;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  open_row;

    logic hs, wait_done, ref_expire;

    // A pending refresh blocks new requests. The request side wins only when
    // an expiry lands in the same cycle as the handshake, because ref_pending
    // is still low during that cycle.
    assign hs         = (state == S_IDLE) && bus.req_valid && !ref_pending;
    assign wait_done  = (wait_cnt == '0);
    assign ref_expire = (state != S_INIT) && (ref_cnt == REF_W'(TREFI - 1));

    always_comb begin
        init_req      = (state == S_INIT);
        bus.req_ready = (state == S_IDLE) && !ref_pending;
        bus.done      = (state == S_RW_WAIT) && wait_done;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_bank  = '0;
        bus.cmd_row   = '0;
        case (state)
            S_PRE, S_CPRE: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_PRE;
                bus.cmd_bank  = lat_bank;
            end
            S_ACT: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_ACT;
                bus.cmd_bank  = lat_bank;
                bus.cmd_row   = lat_row;
            end
            S_RW: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = lat_write ? OP_WR : OP_RD;
                bus.cmd_bank  = lat_bank;
            end
            S_PREA: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_PREA;
            end
            S_REF: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_REF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_INIT;
            wait_cnt    <= '0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
            lat_write   <= 1'b0;
            lat_bank    <= '0;
            lat_row     <= '0;
            valid       <= '0;
            open_row    <= '0;
        end else begin
            // Refresh timer. An expiry while a refresh is already owed is absorbed.
            if (state == S_INIT || ref_expire) ref_cnt <= '0;
            else                               ref_cnt <= ref_cnt + 1'b1;
            if (state == S_REF) ref_pending <= 1'b0;
            if (ref_expire)     ref_pending <= 1'b1;

            // Each issue state loads T-2. The following wait state then spans
            // T-1 cycles, so consecutive commands are exactly T cycles apart.
            if (!wait_done) wait_cnt <= wait_cnt - 1'b1;

            case (state)
                S_INIT: if (init_done) state <= S_IDLE;
                S_IDLE: begin
                    if (hs) begin
                        lat_write <= bus.req_write;
                        lat_bank  <= bus.req_bank;
                        lat_row   <= bus.req_row;
                        if (!valid[bus.req_bank])                          state <= S_ACT;
                        else if (open_row[bus.req_bank] == bus.req_row)    state <= S_RW;
                        else                                               state <= S_PRE;
                    end else if (ref_pending) begin
                        state <= (|valid) ? S_PREA : S_REF;
                    end
                end
                S_PRE: begin
                    valid[lat_bank] <= 1'b0;
                    wait_cnt        <= CNT_W'(TRP - 2);
                    state           <= S_PRE_WAIT;
                end
                S_PRE_WAIT: if (wait_done) state <= S_ACT;
                S_ACT: begin
                    valid[lat_bank]    <= 1'b1;
                    open_row[lat_bank] <= lat_row;
                    wait_cnt           <= CNT_W'(TRCD - 2);
                    state              <= S_ACT_WAIT;
                end
                S_ACT_WAIT: if (wait_done) state <= S_RW;
                S_RW: begin
                    wait_cnt <= lat_write ? CNT_W'(TWR - 2) : CNT_W'(TRD - 2);
                    state    <= S_RW_WAIT;
                end
                S_RW_WAIT: if (wait_done) state <= (CLOSED_PAGE != 0) ? S_CPRE : S_IDLE;
                S_CPRE: begin
                    valid[lat_bank] <= 1'b0;
                    wait_cnt        <= CNT_W'(TRP - 2);
                    state           <= S_CPRE_WAIT;
                end
                S_CPRE_WAIT: if (wait_done) state <= S_IDLE;
                S_PREA: begin
                    valid    <= '0;
                    wait_cnt <= CNT_W'(TRP - 2);
                    state    <= S_PREA_WAIT;
                end
                S_PREA_WAIT: if (wait_done) state <= S_REF;
                S_REF: begin
                    wait_cnt <= CNT_W'(TRFC - 2);
                    state    <= S_REF_WAIT;
                end
                S_REF_WAIT: if (wait_done) state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_bank_cmd_fsm.sv
// Bench for dram_bank_cmd_fsm. Instance A is open-page and instance B is
// closed-page. Every command and done pulse is matched in order against a
// queue of expected {cycle, op, bank, row} events.
module tb_dram_bank_cmd_fsm;
    localparam int NB = 4, BW = 2, RWD = 14;
    localparam int TRP = 3, TRCD = 3, TRD = 4, TWR = 5, TRFC = 8;
    localparam logic [2:0] OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3, OP_PRE = 3'd4,
                           OP_PREA = 3'd5, OP_REF = 3'd6, EV_DONE = 3'd7;
    localparam int K_MISS = 0, K_HIT = 1, K_CONF = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic init_done = 1'b0;
    logic init_req_a, ref_pending_a, init_req_b, ref_pending_b;

    dram_bank_cmd_fsm_if #(.BANK_W(BW), .ROW_W(RWD)) bus_a (), bus_b ();

    dram_bank_cmd_fsm #(.NUM_BANKS(NB), .ROW_W(RWD), .TREFI(100), .CLOSED_PAGE(0)) dut_a (
        .CLK(CLK), .RST(RST), .init_done(init_done), .init_req(init_req_a),
        .ref_pending(ref_pending_a), .bus(bus_a));
    dram_bank_cmd_fsm #(.NUM_BANKS(NB), .ROW_W(RWD), .TREFI(2000), .CLOSED_PAGE(1)) dut_b (
        .CLK(CLK), .RST(RST), .init_done(init_done), .init_req(init_req_b),
        .ref_pending(ref_pending_b), .bus(bus_b));

    always #5 CLK = ~CLK;

    typedef struct packed {
        int              cyc;
        logic [2:0]      op;
        logic [BW-1:0]   bank;
        logic [RWD-1:0]  row;
    } ev_t;

    typedef struct {
        bit             wr;
        logic [BW-1:0]  bank;
        logic [RWD-1:0] row;
        int             kind;
        int             lat;   // handshake to done, cycles
    } vec_t;

    ev_t qa[$], qb[$];
    int  total = 0, bad = 0, cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_cmp(input int which, input ev_t act);
        ev_t e;
        int  n;
        n = (which == 0) ? qa.size() : qb.size();
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL unexpected_ev[%0d]: got cyc=%0d op=%0d bank=%0d row=%0h, expected no event",
                     which, act.cyc, act.op, act.bank, act.row);
        end else begin
            if (which == 0) e = qa.pop_front();
            else            e = qb.pop_front();
            if (act != e) begin
                bad++;
                $display("FAIL ev[%0d]: got cyc=%0d op=%0d bank=%0d row=%0h, expected cyc=%0d op=%0d bank=%0d row=%0h",
                         which, act.cyc, act.op, act.bank, act.row, e.cyc, e.op, e.bank, e.row);
            end
        end
    endtask

    always @(negedge CLK) begin : mon_a
        ev_t e;
        if (bus_a.cmd_valid || bus_a.done) begin
            e.cyc = cyc; e.op = bus_a.done ? EV_DONE : bus_a.cmd_op;
            e.bank = bus_a.cmd_bank; e.row = bus_a.cmd_row;
            mon_cmp(0, e);
        end
    end

    always @(negedge CLK) begin : mon_b
        ev_t e;
        if (bus_b.cmd_valid || bus_b.done) begin
            e.cyc = cyc; e.op = bus_b.done ? EV_DONE : bus_b.cmd_op;
            e.bank = bus_b.cmd_bank; e.row = bus_b.cmd_row;
            mon_cmp(1, e);
        end
    end

    task automatic push(input int which, input int c, input logic [2:0] op,
                        input logic [BW-1:0] b, input logic [RWD-1:0] r);
        ev_t e;
        e.cyc = c; e.op = op; e.bank = b; e.row = r;
        if (which == 0) qa.push_back(e);
        else            qb.push_back(e);
    endtask

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // Hold the request until ready. Returns the handshake cycle, or -1 on timeout.
    task automatic send(input int which, input bit w, input logic [BW-1:0] b,
                        input logic [RWD-1:0] r, output int h);
        bit ok;
        ok = 1'b0;
        h  = -1;
        if (which == 0) begin
            bus_a.req_valid = 1'b1; bus_a.req_write = w; bus_a.req_bank = b; bus_a.req_row = r;
        end else begin
            bus_b.req_valid = 1'b1; bus_b.req_write = w; bus_b.req_bank = b; bus_b.req_row = r;
        end
        for (int i = 0; i < 80 && !ok; i++) begin
            if ((which == 0) ? bus_a.req_ready : bus_b.req_ready) begin
                h  = cyc;
                ok = 1'b1;
            end
            tick();
        end
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        if (!ok) chk("send_timeout", h, 0);
    endtask

    task automatic expect_req(input int which, input int h, input int kind, input int lat,
                              input bit w, input logic [BW-1:0] b, input logic [RWD-1:0] r,
                              input bit closed);
        int t;
        t = h + 1;
        if (kind == K_CONF) begin push(which, t, OP_PRE, b, '0); t += TRP; end
        if (kind != K_HIT)  begin push(which, t, OP_ACT, b, r);  t += TRCD; end
        push(which, t, w ? OP_WR : OP_RD, b, '0);
        push(which, h + lat, EV_DONE, '0, '0);
        if (closed) push(which, h + lat + 1, OP_PRE, b, '0);
    endtask

    // Raise init_done five cycles after b. The return lands on b+6, the first IDLE cycle.
    task automatic do_init(input int b, input bit check);
        for (int i = 0; i <= 5; i++) begin
            if (check) begin
                chk("init_req_a", init_req_a, 1);
                chk("ready_in_init_a", bus_a.req_ready, 0);
            end
            if (i == 5) init_done = 1'b1;
            else        tick();
        end
        tick();
        chk("init_req_after_a", init_req_a, 0);
        chk("ready_after_init_a", bus_a.req_ready, 1);
        chk("ready_after_init_b", bus_b.req_ready, 1);
        chk("start_cycle", cyc, b + 6);
    endtask

    task automatic reset_init(input int ncyc, input bit check, output int b);
        RST = 1'b1;
        init_done = 1'b0;
        repeat (ncyc) tick();
        RST = 1'b0;
        b = cyc;
        do_init(b, check);
    endtask

    initial begin
        vec_t vec [8];
        int   b, h, h2, rc;

        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_bank = '0; bus_a.req_row = '0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_bank = '0; bus_b.req_row = '0;

        vec[0] = '{1'b0, 2'd2, 14'h0010, K_MISS, 7};
        vec[1] = '{1'b0, 2'd2, 14'h0010, K_HIT,  4};
        vec[2] = '{1'b1, 2'd1, 14'h0005, K_MISS, 8};
        vec[3] = '{1'b1, 2'd1, 14'h0006, K_CONF, 11};
        vec[4] = '{1'b1, 2'd1, 14'h0006, K_HIT,  5};
        vec[5] = '{1'b0, 2'd2, 14'h0011, K_CONF, 10};
        vec[6] = '{1'b1, 2'd3, 14'h0000, K_MISS, 8};
        vec[7] = '{1'b0, 2'd3, 14'h3FFF, K_CONF, 10};

        // Reset values and init sequence.
        RST = 1'b1;
        tick();
        chk("rst_init_req_a", init_req_a, 1);
        chk("rst_ref_pending_a", ref_pending_a, 0);
        chk("rst_cmd_valid_a", bus_a.cmd_valid, 0);
        chk("rst_cmd_op_a", bus_a.cmd_op, 0);
        chk("rst_done_a", bus_a.done, 0);
        reset_init(2, 1'b1, b);

        // Open-page request table: miss, hit, conflict for reads and writes.
        h = b + 6;
        for (int i = 0; i < 8; i++) begin
            send(0, vec[i].wr, vec[i].bank, vec[i].row, h);
            expect_req(0, h, vec[i].kind, vec[i].lat, vec[i].wr, vec[i].bank, vec[i].row, 1'b0);
        end
        wait_cyc(h + vec[7].lat + 2);
        chk("qa_drained_table", qa.size(), 0);

        // Closed-page read: the PRE follows done, and ready returns TRP after it.
        reset_init(1, 1'b0, b);
        send(1, 1'b0, 2'd0, 14'h0003, h);
        chk("cp_hs_cycle", h, b + 6);
        expect_req(1, h, K_MISS, 7, 1'b0, 2'd0, 14'h0003, 1'b1);
        wait_cyc(h + 10);
        chk("cp_ready_before", bus_b.req_ready, 0);
        tick();
        chk("cp_ready_after", bus_b.req_ready, 1);
        send(1, 1'b0, 2'd0, 14'h0003, h);
        expect_req(1, h, K_MISS, 7, 1'b0, 2'd0, 14'h0003, 1'b1);
        wait_cyc(h + 10);
        chk("qb_drained", qb.size(), 0);

        // Refresh becoming due while a conflict write is in flight.
        reset_init(1, 1'b0, b);
        send(0, 1'b1, 2'd1, 14'h0005, h);
        expect_req(0, h, K_MISS, 8, 1'b1, 2'd1, 14'h0005, 1'b0);
        wait_cyc(b + 101);
        send(0, 1'b1, 2'd1, 14'h0006, h);
        chk("ref_hs_cycle", h, b + 101);
        expect_req(0, h, K_CONF, 11, 1'b1, 2'd1, 14'h0006, 1'b0);
        push(0, h + 13, OP_PREA, '0, '0);
        push(0, h + 16, OP_REF, '0, '0);
        wait_cyc(h + 4);
        chk("ref_pend_before", ref_pending_a, 0);
        tick();
        chk("ref_pend_rise", ref_pending_a, 1);
        chk("ref_ready_busy", bus_a.req_ready, 0);
        wait_cyc(h + 12);
        chk("ref_ready_idle", bus_a.req_ready, 0);
        wait_cyc(h + 16);
        chk("ref_pend_at_ref", ref_pending_a, 1);
        tick();
        chk("ref_pend_cleared", ref_pending_a, 0);
        chk("ref_ready_refwait", bus_a.req_ready, 0);
        wait_cyc(h + 23);
        chk("ref_ready_last_wait", bus_a.req_ready, 0);
        tick();
        chk("ref_ready_back", bus_a.req_ready, 1);
        // After PREA the table is empty, so the same row is a miss again.
        send(0, 1'b0, 2'd1, 14'h0006, h2);
        chk("post_ref_hs", h2, h + 24);
        expect_req(0, h2, K_MISS, 7, 1'b0, 2'd1, 14'h0006, 1'b0);
        wait_cyc(h2 + 9);
        chk("qa_drained_ref", qa.size(), 0);

        // One-cycle reset during ACT_WAIT: the request is dropped and the table cleared.
        reset_init(1, 1'b0, b);
        send(0, 1'b0, 2'd0, 14'h0007, h);
        push(0, h + 1, OP_ACT, 2'd0, 14'h0007);
        wait_cyc(h + 2);
        RST = 1'b1;
        init_done = 1'b0;
        tick();
        RST = 1'b0;
        chk("midrst_init_req", init_req_a, 1);
        chk("midrst_ready", bus_a.req_ready, 0);
        chk("midrst_done", bus_a.done, 0);
        b = cyc;
        do_init(b, 1'b0);
        rc = -1;
        for (int i = 0; i < 200 && rc < 0; i++) begin
            if (ref_pending_a) rc = cyc;
            else               tick();
        end
        chk("midrst_ref_restart", rc, b + 106);
        // No row should be open, so the refresh goes straight to REF.
        push(0, rc + 1, OP_REF, '0, '0);
        wait_cyc(rc + 1 + TRFC);
        chk("midrst_ready_after_ref", bus_a.req_ready, 1);
        chk("qa_drained_end", qa.size(), 0);
        chk("qb_drained_end", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
